// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, Booth digit codes and digit/cycle counts.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_PA,
        BD_P2A,
        BD_MA,
        BD_M2A
    } bdig_t;

    // Map a multiplier bit triple {b[2i+1], b[2i], b[2i-1]} to its digit.
    function automatic bdig_t booth_code(input logic [2:0] t);
        bdig_t r;
        case (t)
            3'b001, 3'b010: r = BD_PA;
            3'b011:         r = BD_P2A;
            3'b100:         r = BD_M2A;
            3'b101, 3'b110: r = BD_MA;
            default:        r = BD_ZERO;
        endcase
        return r;
    endfunction

    function automatic int num_digits(input int w);
        return w / 2 + 1;
    endfunction

    function automatic int run_cycles(input int w, input int dpc);
        return (num_digits(w) + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator.
// Ports: triple (3-bit digit window), a_ext (extended A), pp (signed product).
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       triple,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] a1;
    logic [WIDTH+2:0] a2;

    // One extra bit so that +/-2A never overflows.
    assign a1 = {a_ext[WIDTH+1], a_ext};
    assign a2 = {a_ext, 1'b0};

    always_comb begin
        pp = '0;
        unique case (booth_code(triple))
            BD_ZERO: pp = '0;
            BD_PA:   pp = a1;
            BD_P2A:  pp = a2;
            BD_MA:   pp = -a1;
            BD_M2A:  pp = -a2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, DPC digits retired per RUN cycle.
// Ports: clk, rst_n, in_valid/in_ready + a, b, is_signed in; out_valid/out_ready + p out; busy.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DPC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int ND = num_digits(WIDTH);
    localparam int NC = run_cycles(WIDTH, DPC);
    localparam int XW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(NC + 1);
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    state_t        state;
    logic [XW-1:0] a_x;
    logic [XW-1:0] b_x;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic [XW:0]   b_t;
    logic [AW-1:0] term [DPC];

    // Implicit b[-1] = 0 sits below the extended multiplier.
    assign b_t = {b_x, 1'b0};

    for (genvar k = 0; k < DPC; k++) begin : g_dig
        int          d;
        logic [XW:0] sh;
        logic [2:0]  trip;
        logic [XW:0] pp;

        // Digit slots past the last real digit contribute nothing.
        always_comb begin
            d    = int'(cnt) * DPC + k;
            sh   = b_t >> (2 * d);
            trip = 3'b000;
            if (d < ND)
                trip = sh[2:0];
        end

        booth_pp_gen #(
            .WIDTH (WIDTH)
        ) u_pp (
            .triple (trip),
            .a_ext  (a_x),
            .pp     (pp)
        );

        assign term[k] = {{(AW-XW-1){pp[XW]}}, pp} << (2 * d);
    end

    always_comb begin
        sum = acc;
        for (int k = 0; k < DPC; k++)
            sum = sum + term[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            acc       <= '0;
            cnt       <= '0;
            a_x       <= '0;
            b_x       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_x      <= is_signed ? {{2{a[WIDTH-1]}}, a}
                                              : {2'b00, a};
                        b_x      <= is_signed ? {{2{b[WIDTH-1]}}, b}
                                              : {2'b00, b};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= sum;
                    if (cnt == LAST)
                        state <= ST_DONE;
                    else
                        cnt <= cnt + 1'b1;
                end
                ST_DONE: begin
                    // First DONE cycle publishes the finished accumulator.
                    if (!out_valid) begin
                        p         <= acc[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and random bench for booth_seq_mul.
// Drives a WIDTH=8/DPC=1 and a WIDTH=16/DPC=2 instance through one shared driver.
module tb_booth_seq_mul;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] av = '0;
    logic [15:0] bv = '0;

    logic        in_ready8, out_valid8, busy8;
    logic [15:0] p8;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] p16;

    logic        rdy, ov, bsy;
    logic [31:0] pv;

    assign rdy = sel ? in_ready16 : in_ready8;
    assign ov  = sel ? out_valid16 : out_valid8;
    assign bsy = sel ? busy16 : busy8;
    assign pv  = sel ? p16 : {16'h0, p8};

    booth_seq_mul #(
        .WIDTH (8),
        .DPC   (1)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & ~sel),
        .in_ready  (in_ready8),
        .a         (av[7:0]),
        .b         (bv[7:0]),
        .is_signed (sgn),
        .out_valid (out_valid8),
        .out_ready (ordy & ~sel),
        .p         (p8),
        .busy      (busy8)
    );

    booth_seq_mul #(
        .WIDTH (16),
        .DPC   (2)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & sel),
        .in_ready  (in_ready16),
        .a         (av),
        .b         (bv),
        .is_signed (sgn),
        .out_valid (out_valid16),
        .out_ready (ordy & sel),
        .p         (p16),
        .busy      (busy16)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; inputs are scrambled while the block is busy.
    task automatic op(input logic s,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [31:0] exp,
                      input int hold);
        int n;
        n = 0;
        while (!rdy && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready", rdy, 1);
        iv = 1'b1;
        sgn = s;
        av = a;
        bv = b;
        tick();
        av = ~a;
        bv = 16'h5A5A;
        sgn = ~s;
        n = 0;
        while (!ov && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, 6);
        chk("p", pv, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", ov, 1);
            chk("hold_p", pv, exp);
            chk("hold_ready", rdy, 0);
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("valid_drop", ov, 0);
        chk("ready_back", rdy, 1);
    endtask

    logic [15:0] ra, rb;
    logic        rs;
    logic [31:0] re;
    int          seen;

    initial begin
        #12;
        sel = 1'b0;
        chk("rst_ready8", rdy, 1);
        chk("rst_valid8", ov, 0);
        chk("rst_busy8", bsy, 0);
        chk("rst_p8", pv, 0);
        sel = 1'b1;
        #1;
        chk("rst_ready16", rdy, 1);
        chk("rst_valid16", ov, 0);
        chk("rst_p16", pv, 0);
        sel = 1'b0;
        rst_n = 1'b1;
        tick();

        op(1'b1, 16'h80, 16'h80, 32'h4000, 0);
        op(1'b0, 16'hFF, 16'hFF, 32'hFE01, 0);
        op(1'b1, 16'hFF, 16'hFF, 32'h0001, 0);
        op(1'b1, 16'hFF, 16'h01, 32'hFFFF, 0);
        op(1'b0, 16'hFF, 16'h01, 32'h00FF, 0);
        op(1'b0, 16'h00, 16'h7F, 32'h0000, 0);
        op(1'b1, 16'h80, 16'h00, 32'h0000, 0);
        op(1'b1, 16'h7F, 16'h7F, 32'h3F01, 0);
        op(1'b1, 16'h80, 16'h7F, 32'hC080, 0);
        op(1'b0, 16'h80, 16'h80, 32'h4000, 0);
        op(1'b0, 16'h12, 16'h34, 32'h03A8, 0);
        op(1'b1, 16'h05, 16'hFD, 32'hFFF1, 0);
        op(1'b0, 16'h0A, 16'h0B, 32'h006E, 5);

        // Abort in the second RUN cycle.
        iv = 1'b1;
        sgn = 1'b0;
        av = 16'h07;
        bv = 16'h09;
        tick();
        iv = 1'b0;
        tick();
        chk("mid_busy", bsy, 1);
        rst_n = 1'b0;
        #2;
        chk("abort_valid", ov, 0);
        chk("abort_busy", bsy, 0);
        chk("abort_ready", rdy, 1);
        chk("abort_p", pv, 0);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov)
                seen++;
        end
        chk("abort_no_valid", seen, 0);
        op(1'b0, 16'h03, 16'h05, 32'h000F, 0);

        sel = 1'b1;
        op(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 0);
        op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rs)
                re = 32'(longint'($signed(ra)) * longint'($signed(rb)));
            else
                re = 32'(longint'(ra) * longint'(rb));
            op(rs, ra, rb, re, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; even, >= 4.
REQ-002 SHALL have parameter DPC, default 1, radix-4 Booth digits retired per cycle; legal values 1 and 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operands and mode presented.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operation.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port is_signed, input, 1, 1 = both operands two's complement, 0 = both unsigned.
REQ-010 SHALL have port out_valid, output, 1, product p valid.
REQ-011 SHALL have port out_ready, input, 1, consumer takes p.
REQ-012 SHALL have port p, output, 2*WIDTH, exact product.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 SHALL assert in_ready only in IDLE; accept on in_valid && in_ready; capture a, b, is_signed; go to RUN.
REQ-016 SHALL extend a and b to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when is_signed=0.
REQ-017 SHALL scan ND = WIDTH/2+1 radix-4 digits of extended b, LSB first, with implicit b[-1]=0.
REQ-018 SHALL decode each digit triple as 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
REQ-019 SHALL add each digit's partial product into a 2*WIDTH+4-bit signed accumulator, shifted by 2 bits per digit position.
REQ-020 SHALL retire DPC digits per RUN cycle, so RUN lasts ceil(ND/DPC) cycles.
REQ-021 SHALL treat surplus digit slots in the final cycle as zero when DPC does not divide ND.
REQ-022 SHALL, after the last RUN cycle, load p with the low 2*WIDTH accumulator bits, set out_valid, and go to DONE.
REQ-023 SHALL hold p and out_valid in DONE until out_ready=1.
REQ-024 SHALL, on out_valid && out_ready, clear out_valid and return to IDLE the next cycle; the new in_ready is visible that cycle.
REQ-025 SHALL set accept-to-out_valid latency to ceil(ND/DPC)+1 clocks (WIDTH=16: 10 clocks for DPC=1, 6 for DPC=2).
REQ-026 SHALL keep p stable from out_valid rise to handshake; p may retain its stale value afterwards.
REQ-027 SHALL ignore changes to a, b, is_signed and in_valid outside IDLE.
REQ-028 SHALL produce exact results at the extremes: signed min*min, unsigned max*max, and any operand 0.

Reset
REQ-029 SHALL, when rst_n is low, force state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator=0, digit counter=0.
REQ-030 SHALL abort any operation interrupted by reset mid-RUN or mid-DONE without producing out_valid.
REQ-031 SHALL resume normal acceptance on the first rising clk edge after rst_n deasserts.

Structure
REQ-032 SHALL place FSM state enum, Booth digit-code constants and the ND/cycle-count helper functions in shared package booth_pkg.
REQ-033 SHALL instantiate DPC copies of one sub-module, booth_pp_gen, each mapping a 3-bit triple and extended A to a signed partial product.
REQ-034 SHALL keep booth_pp_gen combinational; all state lives in booth_seq_mul.

Verification
REQ-035 SHALL cover, with WIDTH=8, DPC=1: is_signed=1, a=0x80, b=0x80 -> p=0x4000, out_valid exactly 6 clocks after accept.
REQ-036 SHALL cover, with WIDTH=8: is_signed=0, a=0xFF, b=0xFF -> p=0xFE01; the same operands with is_signed=1 -> p=0x0001.
REQ-037 SHALL cover, with WIDTH=8: is_signed=1, a=0xFF, b=0x01 -> p=0xFFFF; is_signed=0 -> p=0x00FF.
REQ-038 SHALL cover out_ready held low 5 cycles: p and out_valid stay stable and in_ready stays 0; after the handshake, in_ready=1 next cycle.
REQ-039 SHALL cover rst_n pulsed low in the 2nd RUN cycle: out_valid never rises, and the next operation 3*5 returns p=15.
REQ-040 SHALL cover, with WIDTH=16, DPC=2: 1000 random signed and unsigned pairs matching the reference product, each with 6-clock latency.
